// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG scan sequencer: op codes, TAP navigation
// TMS patterns with their lengths, and the sequencer state encoding.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_DR    = 2'd0,
        OP_IR    = 2'd1,
        OP_RESET = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    // Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [31:0] HDR_DR_TMS = 32'h0000_0001;
    localparam logic [31:0] HDR_DR_LEN = 32'd3;
    // Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [31:0] HDR_IR_TMS = 32'h0000_0003;
    localparam logic [31:0] HDR_IR_LEN = 32'd4;
    // Exit1 -> Update -> Idle
    localparam logic [31:0] TRL_TMS    = 32'h0000_0001;
    localparam logic [31:0] TRL_LEN    = 32'd2;
    // Five TMS=1 reach Test-Logic-Reset from anywhere, then one 0 to Idle
    localparam logic [31:0] RST_TMS    = 32'h0000_001F;
    localparam logic [31:0] RST_LEN    = 32'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA_FETCH,
        S_DATA,
        S_TDO_PUSH,
        S_TRL,
        S_RST
    } state_e;

endpackage

// File: rtl/jtag_shift_seq.sv
// Splits whole IR/DR scan and TAP reset commands into <=32-bit shift-engine
// transactions, adding TAP navigation and streaming TDI/TDO words.
module jtag_shift_seq
    import jtag_pkg::*;
#(
    parameter int unsigned C_MAX_LEN_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [1:0]             CMD_OP,
    input  logic [C_MAX_LEN_W-1:0] CMD_LEN,
    input  logic                   TDI_VALID,
    output logic                   TDI_READY,
    input  logic [31:0]            TDI_DATA,
    output logic                   TDO_VALID,
    input  logic                   TDO_READY,
    output logic [31:0]            TDO_DATA,
    output logic                   BUSY,
    output logic                   PROC_ENABLE,
    output logic [31:0]            PROC_LENGTH,
    output logic [31:0]            PROC_TMS,
    output logic [31:0]            PROC_TDI,
    input  logic                   PROC_DONE,
    input  logic [31:0]            PROC_TDO
);

    state_e                 state_q, state_d;
    logic                   issued_q, issued_d;
    op_e                    op_q, op_d, cmd_op;
    logic [C_MAX_LEN_W-1:0] rem_q, rem_d, rem_left;
    logic [5:0]             chunk_q, chunk_d, chunk_new;
    logic [31:0]            word_q, word_d;
    logic [31:0]            new_mask, q_mask;
    logic                   last_chunk;

    logic        cmd_ready_d, tdi_ready_d, tdo_valid_d, busy_d, proc_enable_d;
    logic [31:0] proc_length_d, proc_tms_d, proc_tdi_d, tdo_data_d;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            issued_q    <= 1'b0;
            op_q        <= OP_DR;
            rem_q       <= '0;
            chunk_q     <= '0;
            word_q      <= '0;
            CMD_READY   <= 1'b0;
            TDI_READY   <= 1'b0;
            TDO_VALID   <= 1'b0;
            BUSY        <= 1'b0;
            PROC_ENABLE <= 1'b0;
            PROC_LENGTH <= '0;
            PROC_TMS    <= '0;
            PROC_TDI    <= '0;
            TDO_DATA    <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            chunk_q     <= chunk_d;
            word_q      <= word_d;
            CMD_READY   <= cmd_ready_d;
            TDI_READY   <= tdi_ready_d;
            TDO_VALID   <= tdo_valid_d;
            BUSY        <= busy_d;
            PROC_ENABLE <= proc_enable_d;
            PROC_LENGTH <= proc_length_d;
            PROC_TMS    <= proc_tms_d;
            PROC_TDI    <= proc_tdi_d;
            TDO_DATA    <= tdo_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        issued_d      = issued_q;
        op_d          = op_q;
        rem_d         = rem_q;
        chunk_d       = chunk_q;
        word_d        = word_q;
        cmd_ready_d   = CMD_READY;
        tdi_ready_d   = 1'b0;
        tdo_valid_d   = TDO_VALID;
        busy_d        = BUSY;
        proc_enable_d = 1'b0;
        proc_length_d = PROC_LENGTH;
        proc_tms_d    = PROC_TMS;
        proc_tdi_d    = PROC_TDI;
        tdo_data_d    = TDO_DATA;

        cmd_op     = op_e'(CMD_OP);
        last_chunk = (rem_q <= C_MAX_LEN_W'(32));
        chunk_new  = last_chunk ? rem_q[5:0] : 6'd32;
        new_mask   = (chunk_new == 6'd32) ? '1 : ((32'd1 << chunk_new) - 32'd1);
        q_mask     = (chunk_q == 6'd32) ? '1 : ((32'd1 << chunk_q) - 32'd1);
        rem_left   = rem_q - C_MAX_LEN_W'(chunk_q);

        // Each transaction state: first cycle raises ENABLE, then waits on DONE.
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                issued_d    = 1'b0;
                if (CMD_VALID && CMD_READY) begin
                    op_d  = cmd_op;
                    rem_d = CMD_LEN;
                    if (cmd_op == OP_RESET) begin
                        state_d     = S_RST;
                        busy_d      = 1'b1;
                        cmd_ready_d = 1'b0;
                    end else if (cmd_op != OP_RSVD && CMD_LEN != '0) begin
                        state_d     = S_HDR;
                        busy_d      = 1'b1;
                        cmd_ready_d = 1'b0;
                    end
                end
            end
            S_HDR: begin
                if (!issued_q) begin
                    issued_d      = 1'b1;
                    proc_enable_d = 1'b1;
                    proc_length_d = (op_q == OP_IR) ? HDR_IR_LEN : HDR_DR_LEN;
                    proc_tms_d    = (op_q == OP_IR) ? HDR_IR_TMS : HDR_DR_TMS;
                    proc_tdi_d    = '0;
                end else if (PROC_DONE) begin
                    issued_d    = 1'b0;
                    state_d     = S_DATA_FETCH;
                    tdi_ready_d = 1'b1;
                end
            end
            S_DATA_FETCH: begin
                if (TDI_VALID && TDI_READY) begin
                    word_d  = TDI_DATA;
                    state_d = S_DATA;
                end else begin
                    tdi_ready_d = 1'b1;
                end
            end
            S_DATA: begin
                if (!issued_q) begin
                    issued_d      = 1'b1;
                    proc_enable_d = 1'b1;
                    chunk_d       = chunk_new;
                    proc_length_d = {26'd0, chunk_new};
                    proc_tms_d    = last_chunk ? (32'd1 << (chunk_new - 6'd1)) : '0;
                    proc_tdi_d    = word_q & new_mask;
                end else if (PROC_DONE) begin
                    issued_d    = 1'b0;
                    state_d     = S_TDO_PUSH;
                    tdo_valid_d = 1'b1;
                    tdo_data_d  = PROC_TDO & q_mask;
                end
            end
            S_TDO_PUSH: begin
                if (TDO_VALID && TDO_READY) begin
                    tdo_valid_d = 1'b0;
                    rem_d       = rem_left;
                    if (rem_left != '0) begin
                        state_d     = S_DATA_FETCH;
                        tdi_ready_d = 1'b1;
                    end else begin
                        state_d = S_TRL;
                    end
                end
            end
            S_TRL, S_RST: begin
                if (!issued_q) begin
                    issued_d      = 1'b1;
                    proc_enable_d = 1'b1;
                    proc_length_d = (state_q == S_TRL) ? TRL_LEN : RST_LEN;
                    proc_tms_d    = (state_q == S_TRL) ? TRL_TMS : RST_TMS;
                    proc_tdi_d    = '0;
                end else if (PROC_DONE) begin
                    issued_d    = 1'b0;
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jtag_shift_seq.sv
// Scoreboard bench for jtag_shift_seq: loopback engine model, TDI source,
// TDO sink, and queues of hand-computed expected transactions and words.
`timescale 1ns/1ps
module tb_jtag_shift_seq;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'd0;
    logic [15:0] CMD_LEN = 16'd0;
    logic        TDI_VALID, TDI_READY;
    logic [31:0] TDI_DATA;
    logic        TDO_VALID, TDO_READY;
    logic [31:0] TDO_DATA;
    logic        BUSY, PROC_ENABLE;
    logic [31:0] PROC_LENGTH, PROC_TMS, PROC_TDI;
    logic        PROC_DONE;
    logic [31:0] PROC_TDO;

    always #5 CLK = ~CLK;

    jtag_shift_seq #(.C_MAX_LEN_W(16)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_LEN(CMD_LEN),
        .TDI_VALID(TDI_VALID), .TDI_READY(TDI_READY), .TDI_DATA(TDI_DATA),
        .TDO_VALID(TDO_VALID), .TDO_READY(TDO_READY), .TDO_DATA(TDO_DATA),
        .BUSY(BUSY), .PROC_ENABLE(PROC_ENABLE), .PROC_LENGTH(PROC_LENGTH),
        .PROC_TMS(PROC_TMS), .PROC_TDI(PROC_TDI), .PROC_DONE(PROC_DONE), .PROC_TDO(PROC_TDO)
    );

    typedef struct {
        logic [31:0] len;
        logic [31:0] tms;
        logic [31:0] tdi;
        int          min_tdo;
    } txn_t;

    txn_t        exp_txn[$];
    logic [31:0] exp_tdo[$];
    logic [31:0] tdi_q[$];

    int n_cmp = 0, n_fail = 0;
    int txn_cnt = 0, tdo_cnt = 0, tdi_cnt = 0;
    int tdo_hold = 0, tdo_stall = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_txn(input logic [31:0] len, input logic [31:0] tms,
                                     input logic [31:0] tdi, input int min_tdo);
        txn_t t;
        t.len = len; t.tms = tms; t.tdi = tdi; t.min_tdo = min_tdo;
        exp_txn.push_back(t);
    endfunction

    // Engine model: captures on ENABLE, answers two cycles later with loopback
    // TDO whose bits above the chunk are forced high so masking is visible.
    initial begin : engine
        int          cnt;
        logic        prev_en;
        logic [31:0] tdo_r;
        txn_t        t;
        cnt = 0; prev_en = 1'b0; tdo_r = '0;
        PROC_DONE = 1'b0; PROC_TDO = '0;
        forever begin
            @(negedge CLK);
            PROC_DONE = 1'b0;
            if (!RESETN) begin
                cnt = 0;
                prev_en = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        PROC_DONE = 1'b1;
                        PROC_TDO  = tdo_r;
                    end
                end
                if (PROC_ENABLE) begin
                    txn_cnt++;
                    check("enable_single_cycle", {31'd0, prev_en}, 32'd0);
                    if (exp_txn.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_txn: got len %0d tms %h tdi %h, required none",
                                 PROC_LENGTH, PROC_TMS, PROC_TDI);
                    end else begin
                        t = exp_txn.pop_front();
                        check("txn_len", PROC_LENGTH, t.len);
                        check("txn_tms", PROC_TMS, t.tms);
                        check("txn_tdi", PROC_TDI, t.tdi);
                        check("txn_after_tdo", {31'd0, (tdo_cnt >= t.min_tdo)}, 32'd1);
                    end
                    tdo_r = (PROC_LENGTH >= 32) ? PROC_TDI : (PROC_TDI | (32'hFFFF_FFFF << PROC_LENGTH));
                    cnt = 2;
                end
                prev_en = PROC_ENABLE;
            end
        end
    end

    // TDI source: VALID depends only on queue contents.
    initial begin : tdi_src
        TDI_VALID = 1'b0; TDI_DATA = '0;
        forever begin
            @(negedge CLK);
            TDI_VALID = (tdi_q.size() > 0);
            TDI_DATA  = TDI_VALID ? tdi_q[0] : 32'd0;
            if (TDI_VALID && TDI_READY && RESETN) begin
                void'(tdi_q.pop_front());
                tdi_cnt++;
            end
        end
    end

    // TDO sink / monitor: compares each accepted word with the scoreboard.
    initial begin : tdo_mon
        TDO_READY = 1'b1;
        forever begin
            @(negedge CLK);
            if (tdo_hold != 0 && TDO_VALID) begin
                tdo_stall = 20;
                tdo_hold  = 0;
            end
            if (tdo_stall > 0) begin
                TDO_READY = 1'b0;
                tdo_stall--;
            end else begin
                TDO_READY = 1'b1;
            end
            if (TDO_VALID && TDO_READY && RESETN) begin
                tdo_cnt++;
                if (exp_tdo.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_tdo: got %h, required none", TDO_DATA);
                end else begin
                    check("tdo_data", TDO_DATA, exp_tdo.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] len);
        int guard;
        guard = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_LEN = len;
        while (!CMD_READY && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check("cmd_accepted", {31'd0, CMD_READY}, 32'd1);
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((BUSY || exp_txn.size() > 0 || exp_tdo.size() > 0) && c < budget) begin
            @(negedge CLK);
            c++;
        end
        check("cmd_complete", {31'd0, (c < budget)}, 32'd1);
        check("idle_busy", {31'd0, BUSY}, 32'd0);
        check("idle_cmd_ready", {31'd0, CMD_READY}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
        check("rst_tdi_ready", {31'd0, TDI_READY}, 32'd0);
        check("rst_tdo_valid", {31'd0, TDO_VALID}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_proc_enable", {31'd0, PROC_ENABLE}, 32'd0);
        check("rst_proc_length", PROC_LENGTH, 32'd0);
        check("rst_proc_tms", PROC_TMS, 32'd0);
        check("rst_proc_tdi", PROC_TDI, 32'd0);
        check("rst_tdo_data", TDO_DATA, 32'd0);
    endtask

    initial begin : stim
        int b, e0, i0, o0, c;

        RESETN = 1'b0;
        #23;
        check_reset_outputs();
        @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", {31'd0, CMD_READY}, 32'd1);

        // DR scan, 8 bits
        b = tdo_cnt;
        push_txn(32'd3, 32'h1, 32'h0, b);
        push_txn(32'd8, 32'h80, 32'hA5, b);
        push_txn(32'd2, 32'h1, 32'h0, b + 1);
        exp_tdo.push_back(32'h0000_00A5);
        tdi_q.push_back(32'h0000_00A5);
        send_cmd(2'd0, 16'd8);
        wait_idle(300);

        // IR scan, 70 bits; upper bits of the last word must be masked off
        b = tdo_cnt;
        push_txn(32'd4, 32'h3, 32'h0, b);
        push_txn(32'd32, 32'h0, 32'h1111_1111, b);
        push_txn(32'd32, 32'h0, 32'h2222_2222, b + 1);
        push_txn(32'd6, 32'h20, 32'h3F, b + 2);
        push_txn(32'd2, 32'h1, 32'h0, b + 3);
        exp_tdo.push_back(32'h1111_1111);
        exp_tdo.push_back(32'h2222_2222);
        exp_tdo.push_back(32'h0000_003F);
        tdi_q.push_back(32'h1111_1111);
        tdi_q.push_back(32'h2222_2222);
        tdi_q.push_back(32'hFFFF_FF3F);
        send_cmd(2'd1, 16'd70);
        wait_idle(600);

        // TAP reset
        e0 = txn_cnt;
        push_txn(32'd6, 32'h1F, 32'h0, tdo_cnt);
        send_cmd(2'd2, 16'd0);
        check("rst_cmd_busy", {31'd0, BUSY}, 32'd1);
        c = 0;
        while (txn_cnt == e0 && c < 100) begin @(negedge CLK); c++; end
        check("rst_cmd_busy_at_issue", {31'd0, BUSY}, 32'd1);
        wait_idle(300);

        // Zero-length DR scan and reserved op: dropped without activity
        e0 = txn_cnt; i0 = tdi_cnt; o0 = tdo_cnt;
        send_cmd(2'd0, 16'd0);
        send_cmd(2'd3, 16'd5);
        repeat (10) @(negedge CLK);
        check("drop_no_enable", txn_cnt - e0, 32'd0);
        check("drop_no_tdi", tdi_cnt - i0, 32'd0);
        check("drop_no_tdo", tdo_cnt - o0, 32'd0);
        check("drop_busy", {31'd0, BUSY}, 32'd0);
        check("drop_cmd_ready", {31'd0, CMD_READY}, 32'd1);

        // DR scan, 64 bits, TDO stalled 20 cycles on the first word
        b = tdo_cnt;
        push_txn(32'd3, 32'h1, 32'h0, b);
        push_txn(32'd32, 32'h0, 32'hCAFE_BABE, b);
        push_txn(32'd32, 32'h8000_0000, 32'h1234_5678, b + 1);
        push_txn(32'd2, 32'h1, 32'h0, b + 2);
        exp_tdo.push_back(32'hCAFE_BABE);
        exp_tdo.push_back(32'h1234_5678);
        tdi_q.push_back(32'hCAFE_BABE);
        tdi_q.push_back(32'h1234_5678);
        tdo_hold = 1;
        send_cmd(2'd0, 16'd64);
        wait_idle(600);

        // Reset asserted during the second data chunk
        b = tdo_cnt; e0 = txn_cnt;
        push_txn(32'd3, 32'h1, 32'h0, b);
        push_txn(32'd32, 32'h0, 32'h0F0F_0F0F, b);
        push_txn(32'd32, 32'h8000_0000, 32'hA0A0_A0A0, b + 1);
        exp_tdo.push_back(32'h0F0F_0F0F);
        tdi_q.push_back(32'h0F0F_0F0F);
        tdi_q.push_back(32'hA0A0_A0A0);
        send_cmd(2'd0, 16'd64);
        c = 0;
        while (txn_cnt < e0 + 3 && c < 300) begin @(negedge CLK); c++; end
        check("abort_reached_chunk2", {31'd0, (txn_cnt >= e0 + 3)}, 32'd1);
        @(posedge CLK);
        #2 RESETN = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        push_txn(32'd6, 32'h1F, 32'h0, tdo_cnt);
        send_cmd(2'd2, 16'd0);
        wait_idle(300);

        repeat (5) @(negedge CLK);
        check("queues_drained", exp_txn.size() + exp_tdo.size() + tdi_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_shift_seq.md
# jtag_shift_seq

Scan sequencer that sits directly upstream of the 32-bit JTAG shift engine. It accepts whole IR-scan, DR-scan and TAP-reset commands of arbitrary length. It splits each command into engine transactions of at most 32 TCK cycles, generating all TAP navigation TMS bits itself, streaming TDI words in and captured TDO words out. The TAP is always left in Run-Test/Idle between commands.

## Interface
- C_MAX_LEN_W, 16: width of the bit-length field; maximum scan is 2^C_MAX_LEN_W-1 bits.
- CLK  in  1  sole clock, shared with the shift engine.
- RESETN  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_OP  in  2  operation: 0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (accepted, no action).
- CMD_LEN  in  C_MAX_LEN_W  scan length in bits; ignored for TAP reset.
- TDI_VALID / TDI_READY  in / out  1  TDI word handshake.
- TDI_DATA  in  32  next 32 scan bits, LSB shifted first.
- TDO_VALID / TDO_READY  out / in  1  TDO word handshake.
- TDO_DATA  out  32  captured bits, LSB first; bits above a partial chunk read 0.
- BUSY  out  1  command in progress.
- PROC_ENABLE  out  1  engine start; engine acts on rising edge.
- PROC_LENGTH  out  32  bits in this transaction (1..32).
- PROC_TMS / PROC_TDI  out  32  per-bit TMS/TDI, bit 0 first.
- PROC_DONE  in  1  one-cycle completion pulse from engine.
- PROC_TDO  in  32  engine capture; valid in the PROC_DONE cycle.

## Operation
- States: IDLE, HDR, DATA_FETCH, DATA, TDO_PUSH, TRL, RST. Each of HDR/DATA/TRL/RST has an issue cycle followed by wait-for-PROC_DONE.
- IDLE: CMD_READY=1. On accept, latch op and length. The next state depends on the command:
  - DR/IR scan with len>0: go to HDR.
  - len==0 scan or reserved op: drop the command, stay IDLE.
  - TAP reset: go to RST.
- HDR: DR sends length 3, TMS=3'b001 (Select-DR, Capture, Shift). IR sends length 4, TMS=4'b0011. TDI=0 in both cases; TDO is discarded.
- DATA_FETCH: TDI_READY=1 until one word is taken.
- DATA: chunk length = min(32, remaining). TMS=0 except when this is the final chunk: then bit (len-1) is set to move to Exit1. TDI=word masked to the chunk length.
- TDO_PUSH: hold PROC_TDO masked to the chunk length until TDO_READY. remaining -= chunk length. If remaining>0 go to DATA_FETCH, else go to TRL.
- TRL: length 2, TMS=2'b01 (Update, Idle), then IDLE.
- RST: length 6, TMS=6'b011111, TDI=0, then IDLE.
- Word counts: a scan of N bits consumes exactly ceil(N/32) TDI words and produces exactly ceil(N/32) TDO words, in order.
- Backpressure: TDO stall blocks the next chunk. TCK stops between chunks, which is legal in stable TAP states (Shift).
- PROC_DONE outside a wait state is ignored.

## Timing
- All outputs registered. Reset values:
  - CMD_READY=0 during reset, then 1 in the first cycle after reset release.
  - TDI_READY=0, TDO_VALID=0, BUSY=0, PROC_ENABLE=0.
  - PROC_LENGTH=0, PROC_TMS=0, PROC_TDI=0, TDO_DATA=0.
- PROC_ENABLE is high for exactly one cycle per transaction. PROC_LENGTH, PROC_TMS and PROC_TDI are stable from that cycle until PROC_DONE. ENABLE is low for at least one cycle between transactions.
- Issue cycle is the cycle after entering a state. TDO_VALID rises the cycle after PROC_DONE.
- BUSY rises the cycle after command accept and falls with the return to IDLE. CMD_READY equals !BUSY except in the accept cycle.
- Handshakes: VALID must not depend on READY. Data transfers when VALID&READY are both high on a CLK edge.
- RESETN asserted mid-command aborts immediately with no trailer; software must issue TAP reset afterwards.

## Structure
- Shared package jtag_pkg holds:
  - op encodings;
  - header, trailer and reset TMS constants and their lengths;
  - state enum.
- Chunk-length and mask computation is inline.
- No sub-module. The top level instantiates the shift engine beside this block, not inside it.

## Test plan
- DR scan, len=8, TDI word 0xA5, TDO loopback model: expected transactions are
  - 3-bit header, TMS 0b001;
  - 8-bit data, TMS 0x80, TDI 0xA5;
  - 2-bit trailer, TMS 0b01.
  - Result: one TDO word 0x000000A5.
- IR scan, len=70, words 0x11111111, 0x22222222, 0x3F:
  - data chunk lengths 32/32/6, last chunk TMS=0x20;
  - three TDO words, third masked to 6 bits.
- TAP reset: single 6-bit transaction with TMS=0x1F; BUSY high throughout, then CMD_READY=1.
- DR scan, len=0: accepted, no PROC_ENABLE pulse, no TDI/TDO handshakes.
- DR scan, len=64, with TDO_READY held low for 20 cycles after the first word: the second data PROC_ENABLE waits until the first TDO word is taken.
- RESETN pulsed during the second data chunk: all outputs return to reset values asynchronously; the next TAP reset command completes normally.
